// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Buffers the core's difftest commit stream (one record per committed
//   instruction) in a DEPTH-entry first-word-fall-through FIFO and drains it
//   over a valid/ready trace port. Every push attempt is tagged with a commit
//   sequence number, so the host can spot lost records as gaps in trace_seq_o.
//   Records that arrive while the FIFO is full are counted (saturating) and
//   flagged through a sticky overflow bit.
//
// Ports
//   clk, resetn      core clock, asynchronous active-low reset
//   clear_i          synchronous flush: empties FIFO, zeroes seq/drop/overflow
//   commit_en_i      one instruction committed this cycle
//   pc_i, instr_i    PC and instruction word of the committed instruction
//   trace_valid_o    head record valid
//   trace_ready_i    host accepts head record
//   trace_pc_o       head record PC
//   trace_instr_o    head record instruction word
//   trace_rvc_o      head record is compressed (instr[1:0] != 2'b11)
//   trace_seq_o      head record sequence number
//   count_o          FIFO occupancy
//   drop_cnt_o       records dropped since reset/clear, saturating
//   overflow_o       sticky: at least one record was dropped
module commit_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             commit_en_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [31:0]      trace_pc_o,
  output logic [31:0]      trace_instr_o,
  output logic             trace_rvc_o,
  output logic [SEQ_W-1:0] trace_seq_o,
  output logic [CW-1:0]    count_o,
  output logic [SEQ_W-1:0] drop_cnt_o,
  output logic             overflow_o
);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem   [DEPTH];

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [SEQ_W-1:0] seq;

  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;
  logic             bypass;
  logic             load_head;
  logic [CW-1:0]    cnt_after_pop;
  logic [CW-1:0]    count_nxt;
  logic [AW-1:0]    rd_nxt;
  logic [31:0]      head_pc;
  logic [31:0]      head_instr;
  logic [SEQ_W-1:0] head_seq;

  always_comb begin
    push          = commit_en_i & ~clear_i;
    pop           = trace_valid_o & trace_ready_i;
    full          = (count_o == CW'(DEPTH));
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    accept        = push & (~full | pop);
    drop          = push & full & ~pop;
    cnt_after_pop = count_o - CW'(pop);
    count_nxt     = cnt_after_pop + CW'(accept);
    rd_nxt        = rd_ptr + AW'(pop);
    // Incoming record becomes the head directly when nothing older remains.
    bypass        = accept & (cnt_after_pop == '0);
    // Outputs are registered copies of the head; reload only when the head
    // changes, otherwise they hold (also holds the last record when empty).
    load_head     = bypass | (pop & (count_nxt != '0));
    if (bypass) begin
      head_pc    = pc_i;
      head_instr = instr_i;
      head_seq   = seq;
    end else begin
      head_pc    = pc_mem[rd_nxt];
      head_instr = instr_mem[rd_nxt];
      head_seq   = seq_mem[rd_nxt];
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
      seq_mem[wr_ptr]   <= seq;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_o       <= '0;
      seq           <= '0;
      drop_cnt_o    <= '0;
      overflow_o    <= 1'b0;
      trace_valid_o <= 1'b0;
      trace_pc_o    <= '0;
      trace_instr_o <= '0;
      trace_rvc_o   <= 1'b0;
      trace_seq_o   <= '0;
    end else if (clear_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_o       <= '0;
      seq           <= '0;
      drop_cnt_o    <= '0;
      overflow_o    <= 1'b0;
      trace_valid_o <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      count_o       <= count_nxt;
      trace_valid_o <= (count_nxt != '0);
      if (push) begin
        seq <= seq + SEQ_W'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) begin
          drop_cnt_o <= drop_cnt_o + SEQ_W'(1);
        end
      end
      if (load_head) begin
        trace_pc_o    <= head_pc;
        trace_instr_o <= head_instr;
        trace_rvc_o   <= (head_instr[1:0] != 2'b11);
        trace_seq_o   <= head_seq;
      end
    end
  end

endmodule
